// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the iterative multiply sequencer: ALU opcodes
// understood by the execute-stage ALU and the sequencer state encoding.
package mul_sequencer_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_ORR = 4'b0011;
   localparam logic [3:0] ALU_EOR = 4'b0110;
   localparam logic [3:0] ALU_RSB = 4'b1000;

   typedef enum logic [1:0] {
      MS_IDLE = 2'b00,
      MS_ITER = 2'b01,
      MS_DONE = 2'b10
   } ms_state_e;

endpackage

// File: rtl/mul_sequencer.sv
// Shift-and-add MUL/MLA sequencer. Borrows the shared execute-stage ALU for
// one ADD per granted cycle, accumulating the partial product in prod_q.
module mul_sequencer
   import mul_sequencer_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             accumulate,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] acc,
   output logic             alu_req,
   input  logic             alu_gnt,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_control,
   input  logic [WIDTH-1:0] alu_result,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic [1:0]       mul_flags
);

   // One extra bit so the counter can never wrap before the final iteration.
   localparam int               CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   ms_state_e        state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] prod_q, prod_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] product_q, product_d;
   logic [1:0]       flags_q, flags_d;

   // Next-state, datapath update and ALU request logic.
   always_comb begin
      state_d     = state_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      prod_d      = prod_q;
      cnt_d       = cnt_q;
      product_d   = product_q;
      flags_d     = flags_q;
      alu_req     = 1'b0;
      alu_a       = '0;
      alu_b       = '0;
      alu_control = ALU_ADD;
      busy        = 1'b0;
      done        = 1'b0;

      case (state_q)
         MS_IDLE: begin
            if (start) begin
               mcand_d  = a;
               mplier_d = b;
               prod_d   = accumulate ? acc : '0;
               cnt_d    = '0;
               state_d  = MS_ITER;
            end
         end

         MS_ITER: begin
            busy    = 1'b1;
            alu_req = 1'b1;
            alu_a   = prod_q;
            alu_b   = mplier_q[0] ? mcand_q : '0;
            // Without a grant every register simply holds and the request stays up.
            if (alu_gnt) begin
               prod_d   = alu_result;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CNT_ONE;
               if ((cnt_q == CNT_LAST) || (EARLY_EXIT && (mplier_d == '0))) begin
                  // Capture the final sum directly so product is valid during DONE.
                  product_d = alu_result;
                  flags_d   = {alu_result[WIDTH-1], (alu_result == '0)};
                  state_d   = MS_DONE;
               end
            end
         end

         MS_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = MS_IDLE;
         end

         default: state_d = MS_IDLE;
      endcase
   end

   // Control state and architecturally visible results, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= MS_IDLE;
         cnt_q     <= '0;
         product_q <= '0;
         flags_q   <= 2'b00;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         flags_q   <= flags_d;
      end
   end

   // Working datapath registers; always reloaded on an accepted start.
   always_ff @(posedge clk) begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
   end

   assign product   = product_q;
   assign mul_flags = flags_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: one instance with full iteration count
// and one with early exit, both sharing stimulus and a behavioural ALU.
module tb_mul_sequencer;
   import mul_sequencer_pkg::*;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] prod;
      logic [1:0]   flags;
      int           iters;
      int           lat;
      int           k;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         accumulate = 1'b0;
   logic [W-1:0] a = '0, b = '0, acc = '0;
   logic         gnt = 1'b1;

   logic         req0, req1, busy0, busy1, done0, done1;
   logic [W-1:0] aa0, aa1, ab0, ab1, res0, res1, prod0, prod1;
   logic [3:0]   ctl0, ctl1;
   logic [1:0]   fl0, fl1;

   int cyc = 0;
   int compared = 0;
   int mismatched = 0;
   int gmode = 0;
   int k_last = 0;
   exp_t sbq0[$];
   exp_t sbq1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] alu_f(input logic [3:0] c, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
      case (c)
         ALU_ADD: return x + y;
         ALU_SUB: return x - y;
         ALU_AND: return x & y;
         ALU_ORR: return x | y;
         ALU_EOR: return x ^ y;
         ALU_RSB: return y - x;
         default: return '0;
      endcase
   endfunction

   assign res0 = alu_f(ctl0, aa0, ab0);
   assign res1 = alu_f(ctl1, aa1, ab1);

   mul_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut (
      .clk(clk), .reset(reset), .start(start), .accumulate(accumulate),
      .a(a), .b(b), .acc(acc), .alu_req(req0), .alu_gnt(gnt), .alu_a(aa0),
      .alu_b(ab0), .alu_control(ctl0), .alu_result(res0), .busy(busy0),
      .done(done0), .product(prod0), .mul_flags(fl0));

   mul_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_ee (
      .clk(clk), .reset(reset), .start(start), .accumulate(accumulate),
      .a(a), .b(b), .acc(acc), .alu_req(req1), .alu_gnt(gnt), .alu_a(aa1),
      .alu_b(ab1), .alu_control(ctl1), .alu_result(res1), .busy(busy1),
      .done(done1), .product(prod1), .mul_flags(fl1));

   // Reference: iterations needed, from the multiplier's bit length.
   function automatic int ref_iters(input logic [W-1:0] mb, input bit ee);
      int n = 0;
      if (!ee) return W;
      for (int i = 0; i < W; i++) if (mb[i]) n = i + 1;
      return (n == 0) ? 1 : n;
   endfunction

   function automatic exp_t ref_model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                      input logic macc, input logic [W-1:0] madd,
                                      input bit ee, input int mode, input int k);
      exp_t e;
      logic [2*W-1:0] full;
      full    = ma * mb + (macc ? {{W{1'b0}}, madd} : '0);
      e.prod  = full[W-1:0];
      e.flags = {e.prod[W-1], e.prod == '0};
      e.iters = ref_iters(mb, ee);
      e.lat   = (mode == 0) ? e.iters : (mode == 1) ? 2 * e.iters : -1;
      e.k     = k;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Grant driver: 0 = always granted, 1 = deny/grant alternating from the
   // first ITER cycle, 2 = random.
   initial begin
      forever begin
         @(posedge clk); #1;
         case (gmode)
            1:       gnt = ((cyc - k_last) % 2) == 1;
            2:       gnt = ($urandom_range(3) != 0);
            default: gnt = 1'b1;
         endcase
      end
   end

   // Monitor: checks every DUT response against the scoreboard.
   initial begin
      int   grants[2];
      logic prev_req[2];
      logic prev_gnt;
      logic [W-1:0] prev_a[2], prev_b[2];
      logic rq, dn, bz;
      logic [W-1:0] xa, xb, xp;
      logic [3:0] xc;
      logic [1:0] xf;
      exp_t e;
      grants = '{0, 0};
      prev_req = '{1'b0, 1'b0};
      prev_gnt = 1'b0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            rq = i == 0 ? req0 : req1;   dn = i == 0 ? done0 : done1;
            bz = i == 0 ? busy0 : busy1; xa = i == 0 ? aa0 : aa1;
            xb = i == 0 ? ab0 : ab1;     xc = i == 0 ? ctl0 : ctl1;
            xp = i == 0 ? prod0 : prod1; xf = i == 0 ? fl0 : fl1;
            if (reset) begin
               grants[i] = 0;
            end else begin
               if (rq) chk($sformatf("alu_control%0d", i), 64'(xc), 64'(ALU_ADD));
               if (prev_req[i] && !prev_gnt && rq) begin
                  chk($sformatf("hold_alu_a%0d", i), 64'(xa), 64'(prev_a[i]));
                  chk($sformatf("hold_alu_b%0d", i), 64'(xb), 64'(prev_b[i]));
               end
               if (rq && gnt) grants[i]++;
               if (dn) begin
                  if ((i == 0 ? sbq0.size() : sbq1.size()) == 0) begin
                     chk($sformatf("unexpected_done%0d", i), 64'(1), 64'(0));
                  end else begin
                     e = (i == 0) ? sbq0.pop_front() : sbq1.pop_front();
                     chk($sformatf("product%0d", i), 64'(xp), 64'(e.prod));
                     chk($sformatf("flags%0d", i), 64'(xf), 64'(e.flags));
                     chk($sformatf("busy_in_done%0d", i), 64'(bz), 64'(1));
                     chk($sformatf("req_in_done%0d", i), 64'(rq), 64'(0));
                     chk($sformatf("iterations%0d", i), 64'(grants[i]), 64'(e.iters));
                     if (e.lat >= 0)
                        chk($sformatf("latency%0d", i), 64'(cyc - e.k), 64'(e.lat));
                  end
                  grants[i] = 0;
               end
            end
            prev_req[i] = rq;
            prev_a[i] = xa;
            prev_b[i] = xb;
         end
         prev_gnt = gnt;
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((busy0 || busy1) && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 400) chk("idle_timeout", 64'(1), 64'(0));
   endtask

   task automatic do_mul(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic macc,
                         input logic [W-1:0] madd, input int mode);
      wait_idle();
      a = ma; b = mb; accumulate = macc; acc = madd;
      gmode = mode;
      k_last = cyc + 1;
      sbq0.push_back(ref_model(ma, mb, macc, madd, 1'b0, mode, k_last));
      sbq1.push_back(ref_model(ma, mb, macc, madd, 1'b1, mode, k_last));
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'({busy0, busy1}), 64'(0));
      chk("rst_done", 64'({done0, done1}), 64'(0));
      chk("rst_req", 64'({req0, req1}), 64'(0));
      chk("rst_product", 64'({prod0, prod1}), 64'(0));
      chk("rst_flags", 64'({fl0, fl1}), 64'(0));
      chk("rst_alu_ab", 64'({aa0 | ab0, aa1 | ab1}), 64'(0));
      chk("rst_alu_ctl", 64'({ctl0, ctl1}), 64'(0));
      reset = 1'b0;
      @(posedge clk); #1;

      do_mul(32'd3, 32'd5, 1'b0, 32'd0, 0);
      do_mul(32'd7, 32'd6, 1'b1, 32'd100, 0);
      do_mul(32'd1, 32'd1, 1'b1, 32'hFFFF_FFFF, 0);
      do_mul(32'hFFFF_FFFF, 32'd2, 1'b0, 32'd0, 0);
      do_mul(32'd12345, 32'd6789, 1'b0, 32'd0, 1);

      // Abort mid-operation: reset lands while the full-length unit is at cnt=10.
      do_mul(32'd5, 32'h8000_0003, 1'b0, 32'd0, 0);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      sbq0.delete();
      sbq1.delete();
      @(posedge clk); #1;
      chk("abort_busy", 64'({busy0, busy1}), 64'(0));
      chk("abort_done", 64'({done0, done1}), 64'(0));
      chk("abort_product", 64'({prod0, prod1}), 64'(0));
      reset = 1'b0;
      @(posedge clk); #1;
      do_mul(32'd3, 32'd5, 1'b1, 32'd2, 0);

      // Early-exit case plus starts presented during ITER and DONE.
      do_mul(32'd9, 32'd4, 1'b0, 32'd0, 0);
      @(posedge clk); #1;
      a = 32'd77; b = 32'd11; start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;

      for (int t = 0; t < 20; t++) begin
         logic [W-1:0] rb;
         rb = $urandom();
         if (t % 2 == 1) rb = rb >> $urandom_range(31);
         do_mul($urandom(), rb, 1'($urandom_range(1)), $urandom(), 2);
      end

      n = 0;
      while ((sbq0.size() != 0 || sbq1.size() != 0) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("scoreboard_drained", 64'(sbq0.size() + sbq1.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
